// File: rtl/filt_pkg.sv
// Shared types and default widths for the filter / sample capture datapath.
package filt_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 15;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_t;

endpackage

// File: rtl/sample_decimator.sv
// Modulo decim+1 sample counter; keep is high when the next sample should be stored.
module sample_decimator (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] decim,
  output logic       keep
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] decim_q, decim_d;

  // The ratio is captured on clear so it stays fixed for a whole capture.
  always_comb begin
    cnt_d   = cnt_q;
    decim_d = decim_q;
    if (clr) begin
      cnt_d   = '0;
      decim_d = decim;
    end else if (en) begin
      cnt_d = (cnt_q == decim_q) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      decim_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      decim_q <= decim_d;
    end
  end

  assign keep = (cnt_q == 8'd0);

endmodule

// File: rtl/sample_capture.sv
// Arm/trigger capture of filtered samples into an external single-port RAM,
// with optional decimation; fills addresses 0..DEPTH-1 then holds in DONE.
module sample_capture
  import filt_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = filt_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [7:0]        decim,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);

  localparam int            DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  cap_state_t          state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                arm_ok, accept, dec_en, keep;

  sample_decimator u_decim (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm_ok),
    .en    (dec_en),
    .decim (decim),
    .keep  (keep)
  );

  // The trigger sample also advances the decimator so it counts as phase 0.
  always_comb begin
    arm_ok = arm && !abort && (state_q == IDLE || state_q == DONE);
    dec_en = sample_valid && !abort &&
             ((state_q == ARMED && trig) || state_q == CAPTURE);
    accept = sample_valid && !abort &&
             ((state_q == ARMED && trig) || (state_q == CAPTURE && keep));

    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (arm_ok) ptr_d = '0;

    if (accept) begin
      wr_addr_d = ptr_q[ADDR_W-1:0];
      wr_data_d = sample_in;
      ptr_d     = ptr_q + ONE;
    end

    case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED,
      CAPTURE: if (accept) state_d = (ptr_q == LAST) ? DONE : CAPTURE;
      DONE:    if (arm) state_d = ARMED;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle arm.
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = ptr_q;
  assign busy    = (state_q == ARMED) || (state_q == CAPTURE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sample_capture.sv
// Randomised and directed check of sample_capture against a behavioural capture model.
module tb_sample_capture;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  localparam int M_IDLE    = 0;
  localparam int M_ARMED   = 1;
  localparam int M_CAPTURE = 2;
  localparam int M_DONE    = 3;

  logic          clk = 1'b0;
  logic          rst, arm, abort, trig, sample_valid;
  logic [7:0]    decim;
  logic [DW-1:0] sample_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   count;
  logic          busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_ptr, m_since, m_decim;
  int e_wr_en, e_addr, e_data;

  always #5 clk = ~clk;

  sample_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .trig         (trig),
    .decim        (decim),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .count        (count),
    .busy         (busy),
    .done         (done)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimation is modelled as "keep every (decim+1)-th sample counted from the trigger".
  task automatic modelStep();
    bit acc;
    acc = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_ptr = 0; m_since = 0; m_decim = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0;
    end else begin
      e_wr_en = 0;
      if (abort) m_mode = M_IDLE;
      else begin
        case (m_mode)
          M_IDLE, M_DONE:
            if (arm) begin
              m_mode = M_ARMED; m_ptr = 0; m_since = 0; m_decim = int'(decim);
            end
          M_ARMED:
            if (sample_valid && trig) begin acc = 1'b1; m_since = 1; end
          M_CAPTURE:
            if (sample_valid) begin
              acc = ((m_since % (m_decim + 1)) == 0);
              m_since++;
            end
          default: m_mode = M_IDLE;
        endcase
      end
      if (acc) begin
        e_wr_en = 1; e_addr = m_ptr; e_data = int'(sample_in);
        m_ptr++;
        m_mode = (m_ptr == DEPTH) ? M_DONE : M_CAPTURE;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("wr_en", int'(wr_en), e_wr_en);
    if (e_wr_en != 0) begin
      checkOutput("wr_addr", int'(wr_addr), e_addr);
      checkOutput("wr_data", int'(wr_data), e_data);
    end
    checkOutput("count", int'(count), m_ptr);
    checkOutput("busy", int'(busy), int'(m_mode == M_ARMED || m_mode == M_CAPTURE));
    checkOutput("done", int'(done), int'(m_mode == M_DONE));
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit ab, input bit tg,
                               input logic [7:0] dc, input bit sv, input logic [DW-1:0] si);
    rst = r; arm = a; abort = ab; trig = tg; decim = dc;
    sample_valid = sv; sample_in = si;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0; decim = '0;
    sample_valid = 1'b0; sample_in = '0;

    // reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_wr_addr", int'(wr_addr), 0);
    checkOutput("rst_wr_data", int'(wr_data), 0);

    // decim=0: every sample from the trigger on, consecutive addresses
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) applyStimulus(0, 0, 0, 1, 0, 1, DW'(i));

    // decim=3: samples 1,5,9 kept out of 12
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 3, 0, 0);
    for (int i = 1; i <= 12; i++) applyStimulus(0, 0, 0, 1, 3, 1, DW'(i));
    checkOutput("decim3_count", int'(count), 3);

    // fill the whole RAM, extra samples are dropped
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) applyStimulus(0, 0, 0, 1, 0, 1, DW'(16'h100 + i));
    checkOutput("full_count", int'(count), DEPTH);
    checkOutput("full_done", int'(done), 1);

    // abort the cycle after the 5th write
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 0, 1, 0, 1, DW'(16'h200 + i));
    applyStimulus(0, 0, 1, 1, 0, 1, 16'h2ff);
    checkOutput("abort_count", int'(count), 5);
    checkOutput("abort_busy", int'(busy), 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 1, 0, 1, DW'(16'h210 + i));

    // arm+abort together in IDLE, then arm while capturing is ignored
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("arm_abort_busy", int'(busy), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 1, 0, 1, DW'(16'h300 + i));
    applyStimulus(0, 1, 0, 1, 0, 1, 16'h3aa);
    for (int i = 1; i <= 2; i++) applyStimulus(0, 0, 0, 0, 0, 1, DW'(16'h310 + i));
    checkOutput("arm_in_capture_count", int'(count), 6);

    // reset after 7 writes, then restart at address 0
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) applyStimulus(0, 0, 0, 1, 0, 1, DW'(16'h400 + i));
    applyStimulus(1, 0, 0, 1, 0, 1, 16'h4ff);
    checkOutput("rst_mid_wr_addr", int'(wr_addr), 0);
    checkOutput("rst_mid_wr_data", int'(wr_data), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 16'h4a1);
    checkOutput("rearm_addr", int'(wr_addr), 0);
    checkOutput("rearm_count", int'(count), 1);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(499) == 0, $urandom_range(15) == 0,
                    $urandom_range(79) == 0, $urandom_range(3) == 0,
                    8'($urandom_range(3)), $urandom_range(2) != 0, DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
